cook_controller: RTL and testbench



---
 rtl/cook_controller_pkg.sv | 25 ++
 rtl/cook_controller_edge_detect.sv | 36 +++
 rtl/cook_controller.sv | 169 ++++++++++++++++
 tb/tb_cook_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cook_controller_pkg.sv
// ============================================================================
// cook_controller_pkg : shared state encoding, widths and default limits
// Revision: 1.0
// ============================================================================
`default_nettype none

package cook_controller_pkg;

  localparam int c_SEC_W             = 4;
  localparam int c_MAX_TIME_DEF      = 15;
  localparam int c_SIREN_SECONDS_DEF = 5;

  localparam logic [c_SEC_W-1:0] c_SEC_ZERO = '0;
  localparam logic [c_SEC_W-1:0] c_SEC_ONE  = c_SEC_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cook_controller_edge_detect.sv
// ============================================================================
// edge_detect : rising-edge detector whose history resets high, so a level
// already asserted when reset releases is not reported as an edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module edge_detect
  import cook_controller_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/cook_controller.sv
// ============================================================================
// cook_controller : cooking sequence FSM; loads the countdown timer, tracks
// remaining seconds from 1 Hz ticks and drives heater, lamp and siren.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cook_controller
  import cook_controller_pkg::*;
#(
  parameter int MAX_TIME      = c_MAX_TIME_DEF,
  parameter int SIREN_SECONDS = c_SIREN_SECONDS_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [c_SEC_W-1:0] time_value,
  input  logic               start_btn,
  input  logic               cancel_btn,
  input  logic               door_open,
  input  logic               one_hz_enable,
  input  logic               half_hz_enable,
  output logic               start_timer,
  output logic [c_SEC_W-1:0] timer_value,
  output logic               heater_on,
  output logic               lamp_on,
  output logic               siren_on,
  output logic [c_SEC_W-1:0] remaining,
  output logic [1:0]         state
);

  localparam logic [c_SEC_W-1:0] c_MAX   = c_SEC_W'(MAX_TIME);
  localparam logic [c_SEC_W-1:0] c_SIREN = c_SEC_W'(SIREN_SECONDS);

  logic w_start_rise;
  logic w_cancel_rise;
  logic w_start;
  logic w_cancel;
  logic [c_SEC_W-1:0] w_clamped;

  state_t             state_q,       state_d;
  logic [c_SEC_W-1:0] remaining_q,   remaining_d;
  logic [c_SEC_W-1:0] siren_cnt_q,   siren_cnt_d;
  logic               start_timer_q, start_timer_d;
  logic [c_SEC_W-1:0] timer_value_q, timer_value_d;
  logic               heater_on_q,   heater_on_d;
  logic               lamp_on_q,     lamp_on_d;
  logic               siren_on_q,    siren_on_d;

  edge_detect u_start_edge (
    .clock (clock),
    .reset (reset),
    .din   (start_btn),
    .rise  (w_start_rise)
  );

  edge_detect u_cancel_edge (
    .clock (clock),
    .reset (reset),
    .din   (cancel_btn),
    .rise  (w_cancel_rise)
  );

  // Presses landing in the cycle a load pulse is out are dropped, which keeps
  // start_timer from ever being high on two consecutive cycles.
  assign w_start   = w_start_rise  & ~start_timer_q;
  assign w_cancel  = w_cancel_rise & ~start_timer_q;
  assign w_clamped = (time_value > c_MAX) ? c_MAX : time_value;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    siren_cnt_d   = siren_cnt_q;
    start_timer_d = 1'b0;
    timer_value_d = timer_value_q;

    unique case (state_q)
      IDLE: begin
        if (!w_cancel && !door_open && w_start && (time_value != c_SEC_ZERO)) begin
          state_d       = COOK;
          remaining_d   = w_clamped;
          start_timer_d = 1'b1;
          timer_value_d = w_clamped;
        end
      end
      COOK: begin
        if (w_cancel) begin
          state_d       = IDLE;
          remaining_d   = c_SEC_ZERO;
          start_timer_d = 1'b1;
          timer_value_d = c_SEC_ZERO;
        end else if (door_open) begin
          state_d = PAUSE;
        end else if (one_hz_enable) begin
          if (remaining_q <= c_SEC_ONE) begin
            state_d     = DONE;
            remaining_d = c_SEC_ZERO;
            siren_cnt_d = c_SIREN;
          end else begin
            remaining_d = remaining_q - c_SEC_ONE;
          end
        end
      end
      PAUSE: begin
        if (w_cancel) begin
          state_d       = IDLE;
          remaining_d   = c_SEC_ZERO;
          start_timer_d = 1'b1;
          timer_value_d = c_SEC_ZERO;
        end else if (!door_open && w_start) begin
          state_d       = COOK;
          start_timer_d = 1'b1;
          timer_value_d = remaining_q;
        end
      end
      DONE: begin
        if (w_cancel || door_open) begin
          state_d     = IDLE;
          siren_cnt_d = c_SEC_ZERO;
        end else if (one_hz_enable) begin
          if (siren_cnt_q <= c_SEC_ONE) begin
            state_d     = IDLE;
            siren_cnt_d = c_SEC_ZERO;
          end else begin
            siren_cnt_d = siren_cnt_q - c_SEC_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge.
    heater_on_d = (state_d == COOK);
    lamp_on_d   = (state_d == COOK) || (state_d == PAUSE);
    siren_on_d  = (state_d == DONE) && half_hz_enable;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      remaining_q   <= c_SEC_ZERO;
      siren_cnt_q   <= c_SEC_ZERO;
      start_timer_q <= 1'b0;
      timer_value_q <= c_SEC_ZERO;
      heater_on_q   <= 1'b0;
      lamp_on_q     <= 1'b0;
      siren_on_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      siren_cnt_q   <= siren_cnt_d;
      start_timer_q <= start_timer_d;
      timer_value_q <= timer_value_d;
      heater_on_q   <= heater_on_d;
      lamp_on_q     <= lamp_on_d;
      siren_on_q    <= siren_on_d;
    end
  end

  assign start_timer = start_timer_q;
  assign timer_value = timer_value_q;
  assign heater_on   = heater_on_q;
  assign lamp_on     = lamp_on_q;
  assign siren_on    = siren_on_q;
  assign remaining   = remaining_q;
  assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cook_controller.sv
// ============================================================================
// tb_cook_controller : scenario tasks plus a scoreboard of expected timer loads
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cook_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] time_value = 4'd0;
  logic       start_btn = 1'b0;
  logic       cancel_btn = 1'b0;
  logic       door_open = 1'b0;
  logic       one_hz_enable = 1'b0;
  logic       half_hz_enable = 1'b0;

  logic       start_timer, heater_on, lamp_on, siren_on;
  logic [3:0] timer_value, remaining;
  logic [1:0] state;

  logic       start_timer2, heater_on2, lamp_on2, siren_on2;
  logic [3:0] timer_value2, remaining2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic       prev_st = 1'b0;

  localparam logic [1:0] S_IDLE = 2'd0, S_COOK = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  cook_controller #(.MAX_TIME(15), .SIREN_SECONDS(5)) dut (
    .clock(clock), .reset(reset), .time_value(time_value),
    .start_btn(start_btn), .cancel_btn(cancel_btn), .door_open(door_open),
    .one_hz_enable(one_hz_enable), .half_hz_enable(half_hz_enable),
    .start_timer(start_timer), .timer_value(timer_value), .heater_on(heater_on),
    .lamp_on(lamp_on), .siren_on(siren_on), .remaining(remaining), .state(state)
  );

  cook_controller #(.MAX_TIME(9), .SIREN_SECONDS(5)) dut9 (
    .clock(clock), .reset(reset), .time_value(time_value),
    .start_btn(start_btn), .cancel_btn(cancel_btn), .door_open(door_open),
    .one_hz_enable(one_hz_enable), .half_hz_enable(half_hz_enable),
    .start_timer(start_timer2), .timer_value(timer_value2), .heater_on(heater_on2),
    .lamp_on(lamp_on2), .siren_on(siren_on2), .remaining(remaining2), .state(state2)
  );

  always #5 clock = ~clock;

  // Scoreboard: each load pulse of the main instance pops one expected value.
  always @(negedge clock) begin
    if (start_timer) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_pulse: unexpected start_timer with timer_value=%0d, required no pulse", timer_value);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (timer_value !== e) begin
          errors++;
          $display("FAIL sb_timer_value: got %0d, required %0d", timer_value, e);
        end
      end
      checks++;
      if (prev_st) begin
        errors++;
        $display("FAIL sb_back_to_back: start_timer high two cycles running, required single cycle");
      end
    end
    prev_st <= start_timer;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
  endtask

  task automatic press_start(input logic [3:0] exp_load);
    exp_q.push_back(exp_load);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic press_cancel();
    exp_q.push_back(4'd0);
    cancel_btn = 1'b1;
    step();
    cancel_btn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d, required 0", state); end
    checks++; if ({start_timer, heater_on, lamp_on, siren_on} !== 4'b0) begin errors++;
      $display("FAIL reset_outputs: got st/ht/lp/sr=%b, required 0000", {start_timer, heater_on, lamp_on, siren_on}); end
    checks++; if ({timer_value, remaining} !== 8'h00) begin errors++;
      $display("FAIL reset_values: got timer_value=%0d remaining=%0d, required 0 0", timer_value, remaining); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_normal_cook();
    time_value = 4'd3;
    press_start(4'd3);
    checks++; if (start_timer !== 1'b1 || state !== S_COOK || heater_on !== 1'b1 || remaining !== 4'd3) begin errors++;
      $display("FAIL cook_start: got st=%b state=%0d heater=%b rem=%0d, required 1 1 1 3", start_timer, state, heater_on, remaining); end
    step();
    checks++; if (start_timer !== 1'b0) begin errors++; $display("FAIL cook_pulse_width: got %b, required 0", start_timer); end
    for (int i = 2; i >= 1; i--) begin
      tick();
      checks++; if (remaining !== 4'(i) || state !== S_COOK) begin errors++;
        $display("FAIL cook_count: got rem=%0d state=%0d, required %0d 1", remaining, state, i); end
    end
    half_hz_enable = 1'b1;
    tick();
    checks++; if (state !== S_DONE || remaining !== 4'd0 || heater_on !== 1'b0 || siren_on !== 1'b1) begin errors++;
      $display("FAIL cook_done: got state=%0d rem=%0d heater=%b siren=%b, required 3 0 0 1", state, remaining, heater_on, siren_on); end
    for (int i = 0; i < 5; i++) begin
      half_hz_enable = (i % 2 == 1);
      tick();
      checks++; if (state !== ((i < 4) ? S_DONE : S_IDLE) || siren_on !== ((i < 4) && (i % 2 == 1))) begin errors++;
        $display("FAIL siren_phase%0d: got state=%0d siren=%b, required %0d %b", i, state, siren_on,
                 (i < 4) ? S_DONE : S_IDLE, (i < 4) && (i % 2 == 1)); end
    end
    half_hz_enable = 1'b0;
    step();
  endtask

  task automatic test_pause_resume();
    time_value = 4'd5;
    press_start(4'd5);
    step();
    tick();
    tick();
    door_open = 1'b1;
    step();
    checks++; if (state !== S_PAUSE || remaining !== 4'd3 || lamp_on !== 1'b1 || heater_on !== 1'b0) begin errors++;
      $display("FAIL pause_enter: got state=%0d rem=%0d lamp=%b heater=%b, required 2 3 1 0", state, remaining, lamp_on, heater_on); end
    tick();
    tick();
    checks++; if (state !== S_PAUSE || remaining !== 4'd3) begin errors++;
      $display("FAIL pause_ticks: got state=%0d rem=%0d, required 2 3", state, remaining); end
    door_open = 1'b0;
    step();
    press_start(4'd3);
    checks++; if (state !== S_COOK || heater_on !== 1'b1 || start_timer !== 1'b1) begin errors++;
      $display("FAIL resume: got state=%0d heater=%b st=%b, required 1 1 1", state, heater_on, start_timer); end
    step();
    press_cancel();
    checks++; if (state !== S_IDLE || remaining !== 4'd0 || lamp_on !== 1'b0) begin errors++;
      $display("FAIL resume_cancel: got state=%0d rem=%0d lamp=%b, required 0 0 0", state, remaining, lamp_on); end
    step();
  endtask

  task automatic test_clamp_reject();
    time_value = 4'd0;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    checks++; if (state !== S_IDLE || start_timer !== 1'b0 || start_timer2 !== 1'b0) begin errors++;
      $display("FAIL zero_reject: got state=%0d st=%b st9=%b, required 0 0 0", state, start_timer, start_timer2); end
    step();
    time_value = 4'd12;
    press_start(4'd12);
    checks++; if (start_timer2 !== 1'b1 || timer_value2 !== 4'd9 || remaining2 !== 4'd9) begin errors++;
      $display("FAIL clamp9: got st=%b timer_value=%0d rem=%0d, required 1 9 9", start_timer2, timer_value2, remaining2); end
    step();
    press_cancel();
    step();
  endtask

  task automatic test_simultaneous();
    time_value = 4'd4;
    press_start(4'd4);
    step();
    exp_q.push_back(4'd0);
    cancel_btn = 1'b1;
    one_hz_enable = 1'b1;
    step();
    cancel_btn = 1'b0;
    one_hz_enable = 1'b0;
    checks++; if (state !== S_IDLE || remaining !== 4'd0 || start_timer !== 1'b1) begin errors++;
      $display("FAIL cancel_tick: got state=%0d rem=%0d st=%b, required 0 0 1", state, remaining, start_timer); end
    step();
    press_start(4'd4);
    step();
    tick();
    door_open = 1'b1;
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
    checks++; if (state !== S_PAUSE || remaining !== 4'd3) begin errors++;
      $display("FAIL door_tick: got state=%0d rem=%0d, required 2 3", state, remaining); end
    door_open = 1'b0;
    press_cancel();
    step();
  endtask

  task automatic test_reset_held_button();
    time_value = 4'd6;
    press_start(4'd6);
    step();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state !== S_IDLE || heater_on !== 1'b0 || lamp_on !== 1'b0 || remaining !== 4'd0 || timer_value !== 4'd0) begin errors++;
      $display("FAIL async_reset: got state=%0d heater=%b lamp=%b rem=%0d tv=%0d, required all 0", state, heater_on, lamp_on, remaining, timer_value); end
    start_btn = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (state !== S_IDLE || heater_on !== 1'b0) begin errors++;
      $display("FAIL held_button: got state=%0d heater=%b, required 0 0", state, heater_on); end
    start_btn = 1'b0;
    step();
    press_start(4'd6);
    checks++; if (state !== S_COOK || remaining !== 4'd6) begin errors++;
      $display("FAIL repress: got state=%0d rem=%0d, required 1 6", state, remaining); end
    step();
    press_cancel();
    step();
  endtask

  initial begin
    test_reset();
    test_normal_cook();
    test_pause_resume();
    test_clamp_reject();
    test_simultaneous();
    test_reset_held_button();
    step();
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL sb_drain: %0d expected loads never seen, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
